// File: rtl/game_round_fsm.sv
// game_round_fsm: timed multi-round game controller.
// The player must land WIN_COUNT hits; every round allows TIME_LIMIT ticks.
// Produces per-digit codes for the shared seven-segment decoder/mux plus
// victory/loss flags. Digit codes: 0..9 decimal, 5'h10 dash, 5'h1F blank.
module game_round_fsm #(
  parameter int NUM_DIGITS = 4,
  parameter int WIN_COUNT  = 4,
  parameter int TIME_LIMIT = 9,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    hit,
  input  logic                    tick,
  output logic [5*NUM_DIGITS-1:0] bits,
  output logic                    victoryflag,
  output logic                    lossflag,
  output logic [CNT_W-1:0]        game_counter
);

  localparam int DIG_W = 5;
  localparam int BUS_W = DIG_W * NUM_DIGITS;

  localparam logic [DIG_W-1:0] CODE_DASH  = 5'h10;
  localparam logic [DIG_W-1:0] CODE_BLANK = 5'h1F;
  localparam logic [DIG_W-1:0] CODE_ZERO  = 5'h00;

  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_COUNT);
  localparam logic [3:0]       TIME_LOAD = 4'(TIME_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  // Builds a full display word from leftmost / middle / rightmost codes.
  function automatic logic [BUS_W-1:0] make_pattern(
    input logic [DIG_W-1:0] left,
    input logic [DIG_W-1:0] mid,
    input logic [DIG_W-1:0] right
  );
    logic [BUS_W-1:0] word;
    word = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d == NUM_DIGITS - 1)
        word[d*DIG_W +: DIG_W] = left;
      else if (d == 0)
        word[d*DIG_W +: DIG_W] = right;
      else
        word[d*DIG_W +: DIG_W] = mid;
    end
    return word;
  endfunction

  localparam logic [BUS_W-1:0] IDLE_BITS = make_pattern(CODE_BLANK, CODE_DASH, CODE_BLANK);

  // Registered state
  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [3:0]       timer_reg;
  logic             blink_reg;
  logic             victory_reg;
  logic             loss_reg;
  logic [BUS_W-1:0] bits_reg;

  // Next-state values
  state_t           state_next;
  logic [CNT_W-1:0] count_next;
  logic [3:0]       timer_next;
  logic             blink_next;

  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] remaining;

  assign count_inc = count_reg + 1'b1;
  assign remaining = WIN_CNT - count_reg;

  // Next-state and counter update; hit takes priority over tick in PLAY
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    blink_next = blink_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PLAY;
          count_next = '0;
          timer_next = TIME_LOAD;
          blink_next = 1'b0;
        end
      end
      PLAY: begin
        if (hit) begin
          // Saturate: the counter never passes WIN_COUNT
          if (count_reg < WIN_CNT) begin
            count_next = count_inc;
            if (count_inc == WIN_CNT)
              state_next = WIN;
          end
          timer_next = TIME_LOAD;
        end else if (tick) begin
          if (timer_reg != 4'd0)
            timer_next = timer_reg - 1'b1;
          else
            state_next = LOSE;
        end
      end
      WIN: begin
        if (start) begin
          state_next = PLAY;
          count_next = '0;
          timer_next = TIME_LOAD;
          blink_next = 1'b0;
        end
      end
      LOSE: begin
        if (start) begin
          state_next = PLAY;
          count_next = '0;
          timer_next = TIME_LOAD;
          blink_next = 1'b0;
        end else if (tick) begin
          blink_next = ~blink_reg;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        timer_next = TIME_LOAD;
        blink_next = 1'b0;
      end
    endcase
  end

  // FSM register; flags decode the incoming state so they move with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      timer_reg   <= TIME_LOAD;
      blink_reg   <= 1'b0;
      victory_reg <= 1'b0;
      loss_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      timer_reg   <= timer_next;
      blink_reg   <= blink_next;
      victory_reg <= (state_next == WIN);
      loss_reg    <= (state_next == LOSE);
    end
  end

  // Display field selection from the current (registered) state
  logic [DIG_W-1:0] left_code;
  logic [DIG_W-1:0] mid_code;
  logic [DIG_W-1:0] right_code;
  logic             all_blank;
  logic [BUS_W-1:0] bits_next;

  // Choose leftmost / middle / rightmost codes for each state
  always_comb begin
    left_code  = CODE_BLANK;
    mid_code   = CODE_DASH;
    right_code = CODE_BLANK;
    all_blank  = 1'b0;
    case (state_reg)
      IDLE: begin
        left_code  = CODE_BLANK;
        right_code = CODE_BLANK;
      end
      PLAY: begin
        left_code  = DIG_W'(remaining);
        right_code = {1'b0, timer_reg};
      end
      WIN: begin
        left_code  = CODE_ZERO;
        right_code = CODE_BLANK;
      end
      LOSE: begin
        if (blink_reg) begin
          all_blank = 1'b1;
        end else begin
          left_code  = DIG_W'(remaining);
          right_code = CODE_ZERO;
        end
      end
      default: begin
        all_blank = 1'b1;
      end
    endcase
  end

  // Per-digit placement; with two digits there is no middle field
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == NUM_DIGITS - 1) begin : g_left
        assign bits_next[gi*DIG_W +: DIG_W] = all_blank ? CODE_BLANK : left_code;
      end else if (gi == 0) begin : g_right
        assign bits_next[gi*DIG_W +: DIG_W] = all_blank ? CODE_BLANK : right_code;
      end else begin : g_mid
        assign bits_next[gi*DIG_W +: DIG_W] = all_blank ? CODE_BLANK : mid_code;
      end
    end
  endgenerate

  // Display register: trails the state by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bits_reg <= IDLE_BITS;
    else
      bits_reg <= bits_next;
  end

  assign bits         = bits_reg;
  assign victoryflag  = victory_reg;
  assign lossflag     = loss_reg;
  assign game_counter = count_reg;

endmodule

// File: tb/tb_game_round_fsm.sv
// Self-checking bench for game_round_fsm with default parameters.
// Expected observations are queued when stimulus is applied and popped
// when the corresponding output sample is taken.
module tb_game_round_fsm;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        hit;
  logic        tick;
  logic [19:0] bits;
  logic        victoryflag;
  logic        lossflag;
  logic [3:0]  game_counter;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [25:0] val;
  } exp_t;

  exp_t sb[$];

  game_round_fsm #(
    .NUM_DIGITS(4),
    .WIN_COUNT (4),
    .TIME_LIMIT(9),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .hit         (hit),
    .tick        (tick),
    .bits        (bits),
    .victoryflag (victoryflag),
    .lossflag    (lossflag),
    .game_counter(game_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display word model: leftmost, two dashes, rightmost
  function automatic logic [19:0] disp(input logic [4:0] l, input logic [4:0] r);
    return {l, 5'h10, 5'h10, r};
  endfunction

  function automatic logic [25:0] pack_exp(input logic [19:0] b, input logic v,
                                           input logic l, input logic [3:0] c);
    return {b, v, l, c};
  endfunction

  function automatic logic [25:0] observed();
    return {bits, victoryflag, lossflag, game_counter};
  endfunction

  function automatic exp_t mk(input string n, input logic [25:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    return e;
  endfunction

  // One-cycle pulse; called at a negedge, returns at the next negedge
  task automatic step(input logic s, input logic h, input logic t);
    start = s; hit = h; tick = t;
    @(negedge clk);
    start = 1'b0; hit = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    sb.push_back(mk("reset_idle", pack_exp(20'hFC21F, 1'b0, 1'b0, 4'd0)));
    idle(3);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  task automatic test_countdown();
    exp_t e;
    step(1, 0, 0);
    sb.push_back(mk("start_play", pack_exp(20'h24209, 1'b0, 1'b0, 4'd0)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    sb.push_back(mk("three_ticks", pack_exp(disp(5'd4, 5'd6), 1'b0, 1'b0, 4'd0)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  task automatic test_win();
    exp_t e;
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 1, 0);
      if (i < 3) begin
        sb.push_back(mk($sformatf("hit_%0d", i + 1),
                        pack_exp(disp(5'(3 - i), 5'd9), 1'b0, 1'b0, 4'(i + 1))));
        idle(1);
      end else begin
        // Flag and counter move on the hit edge; display still shows PLAY
        sb.push_back(mk("win_edge", pack_exp(disp(5'd1, 5'd7), 1'b1, 1'b0, 4'd4)));
      end
      e = sb.pop_front(); vectors++;
      if (observed() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
      end else $display("ok   %s: %h", e.name, observed());
    end
    sb.push_back(mk("win_display", pack_exp(20'h0421F, 1'b1, 1'b0, 4'd4)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 1, 0);
    step(0, 1, 1);
    sb.push_back(mk("win_saturate", pack_exp(20'h0421F, 1'b1, 1'b0, 4'd4)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    sb.push_back(mk("timer_zero", pack_exp(disp(5'd3, 5'd1), 1'b0, 1'b0, 4'd1)));
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 0, 1);
    sb.push_back(mk("loss_edge", pack_exp(disp(5'd3, 5'd0), 1'b0, 1'b1, 4'd1)));
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    sb.push_back(mk("lose_display", pack_exp(20'h1C200, 1'b0, 1'b1, 4'd1)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 0, 1);
    sb.push_back(mk("blink_blank", pack_exp(20'hFFFFF, 1'b0, 1'b1, 4'd1)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 0, 1);
    sb.push_back(mk("blink_restore", pack_exp(20'h1C200, 1'b0, 1'b1, 4'd1)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  task automatic test_hit_tick();
    exp_t e;
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    step(0, 1, 1);
    sb.push_back(mk("hit_tick_edge", pack_exp(disp(5'd4, 5'd0), 1'b0, 1'b0, 4'd1)));
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    sb.push_back(mk("hit_tick_reload", pack_exp(disp(5'd3, 5'd9), 1'b0, 1'b0, 4'd1)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 0, 1);
    sb.push_back(mk("hit_tick_resume", pack_exp(disp(5'd3, 5'd8), 1'b0, 1'b0, 4'd1)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  task automatic test_restart_reset();
    exp_t e;
    // From PLAY with timer 8: eight ticks reach zero, the ninth loses
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    sb.push_back(mk("pre_restart_lose", pack_exp(disp(5'd3, 5'd0), 1'b0, 1'b1, 4'd1)));
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(1, 0, 0);
    sb.push_back(mk("restart", pack_exp(20'h24209, 1'b0, 1'b0, 4'd0)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    step(0, 1, 0);
    step(0, 0, 1);
    idle(1);
    // Reset between clock edges must take effect without a clock
    #2 reset_n = 1'b0;
    sb.push_back(mk("async_reset", pack_exp(20'hFC21F, 1'b0, 1'b0, 4'd0)));
    #1;
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0);
    sb.push_back(mk("post_reset_play", pack_exp(20'h24209, 1'b0, 1'b0, 4'd0)));
    idle(1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, observed(), e.val);
    end else $display("ok   %s: %h", e.name, observed());
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    hit     = 1'b0;
    tick    = 1'b0;
    @(negedge clk);
    test_reset();
    test_countdown();
    test_win();
    test_timeout();
    test_hit_tick();
    test_restart_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Run-length bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
